commit_queue_ctrl: RTL and testbench
====================================

# commit_queue_ctrl

In-order commit sequencer behind the rename stage. It records every renamed instruction in program order, tracks writeback completion and in-order branch resolution, and retires at most one instruction per cycle. Each retirement that writes a destination produces a physical-register commit back to rename (`p_commit`). It also discards wrong-path entries on a mispredict and applies back-pressure to rename when it has no room.

## Interface
- `DEPTH`, 16: queue entries; power of two, ≥4.
- `MAX_BR`, 4: maximum unresolved branches in flight; ≥1.
- `PREG_W`, 6: physical register index width (64 physical registers).
- `clk` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `rn_valid_i` in 1: a renamed instruction is presented this cycle.
- `rn_rd_valid_i` in 1: the instruction writes a destination.
- `rn_rd_idx_i` in PREG_W: physical destination register.
- `rn_is_branch_i` in 1: the instruction is a branch.
- `alloc_tag_o` out log2(DEPTH): queue slot given to the presented instruction; equals the tail pointer.
- `cq_full_o` out 1: no room; combinational from state only.
- `wb_valid_i` in 1: execution writeback.
- `wb_tag_i` in log2(DEPTH): slot that completed.
- `br_valid_i` in 1: the oldest unresolved branch is resolved this cycle.
- `br_hit_i` in 1: 1 = prediction correct, 0 = mispredict.
- `p_commit_valid_o` out 1: registered commit pulse to rename.
- `p_commit_idx_o` out PREG_W: physical register being committed.
- `cq_empty_o` out 1: count == 0.

## Operation
- **State**
  - `head`, `tail`: log2(DEPTH) bits, wrap modulo DEPTH.
  - `count`: log2(DEPTH)+1 bits.
  - Per entry: `valid`, `done`, `rd_valid`, `rd_idx`, `is_br`, `br_resolved`.
  - Branch-tag FIFO, MAX_BR deep, holding queue tags of unresolved branches in order; `br_cnt`.
- **Full:** `cq_full_o` = (count == DEPTH) || (br_cnt == MAX_BR). It is conservative: it asserts even for a non-branch and even when a retire happens in the same cycle.
- **Allocate:** when `rn_valid_i` && !`cq_full_o` && !mispredict:
  - write the entry at `tail` with `done`=0;
  - tail++, count++;
  - if `rn_is_branch_i`, push the tail value onto the branch FIFO.
  - `rn_valid_i` while full is dropped. The producer must hold the instruction; the bench treats this as a protocol error.
- **Writeback:** `wb_valid_i` sets `done[wb_tag_i]` only if that entry is valid. Otherwise the writeback is ignored.
- **Branch resolve:** `br_valid_i` with br_cnt == 0 is ignored. Otherwise pop the oldest branch tag T and set `done[T]`=1 and `br_resolved[T]`=1.
  - Hit: nothing further.
  - Miss: invalidate every entry strictly younger than T; tail = T+1; count = (T+1−head) mod DEPTH, or DEPTH when that is 0 and entry T is valid; clear the branch FIFO (br_cnt=0).
- **Retire:** if entry[head] is valid && `done` (a branch additionally needs `br_resolved`): clear it, head++, count--.
  - If `rd_valid`, the next cycle drives `p_commit_valid_o`=1 and `p_commit_idx_o`=rd_idx.
  - If not, `p_commit_valid_o`=0 next cycle.
- **Priority in one cycle:** retire (oldest) and resolve/flush are applied together. Allocation is suppressed on a mispredict (the incoming instruction is wrong-path). A writeback to a slot flushed in the same cycle is discarded.
- **Reset:**
  - All entries invalid; head=tail=count=br_cnt=0.
  - `p_commit_valid_o`=0, `p_commit_idx_o`=0.
  - `cq_full_o`=0, `cq_empty_o`=1, `alloc_tag_o`=0.
  - Reset asserted mid-operation drops all entries immediately with no commits.

## Timing
- Allocate → entry visible to retire logic: next cycle.
- Writeback in cycle N on the head entry → head advances at edge N+1 → `p_commit_valid_o` high during cycle N+1. The output is registered, so minimum latency from writeback to commit is 1 cycle.
- Retire throughput: 1 per cycle. Back-to-back completed entries produce consecutive commit pulses.
- A mispredict in cycle N frees slots at edge N+1. `cq_full_o` may deassert in cycle N+1.
- `alloc_tag_o`, `cq_full_o` and `cq_empty_o` depend only on registers; there is no combinational path from any input.

## Test plan
- **Fill/drain:** allocate 16 non-branch entries with rd = 32..47 → `cq_full_o`=1 after the 16th. Writeback tags 0..15 in order, one per cycle → 16 consecutive commit pulses with idx 32..47, then `cq_empty_o`=1.
- **Out-of-order writeback:** allocate rd 40, 41, 42; writeback tag 2, then 1, then 0 → no commit until tag 0 completes, then idx 40, 41, 42 on three consecutive cycles.
- **Mispredict flush:** allocate A(rd 33), branch B (tag 1), C(rd 34), D(rd 35). Drive `br_valid_i`=1, `br_hit_i`=0 → tail=2, count=2. Writeback A → commit 33; B retires with no pulse; C and D are never committed; a writeback to tag 2 is ignored.
- **Branch cap:** allocate 4 branches with no resolution → `cq_full_o`=1 with count=4. One hit resolution → `cq_full_o`=0 next cycle.
- **Simultaneous events:** in one cycle, the head retires, `br_valid_i` miss is applied, `rn_valid_i`=1 is presented, and a writeback arrives for a flushed tag → head retire completes, the new instruction is not allocated, and the flushed writeback has no effect.
- **Wrap and reset:** run 40 mixed instructions so that pointers wrap twice; commit order must match allocation order. Assert `rst_ni` low mid-stream → outputs return to reset values within the same cycle and no further `p_commit_valid_o` pulses occur.

Source files
------------

// File: rtl/commit_queue_ctrl_if.sv
// Rename / execute / branch-unit handshake bundle for the in-order commit queue.
interface commit_queue_ctrl_if #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 6
);
  localparam int TAG_W = $clog2(DEPTH);

  logic              rn_valid_i;
  logic              rn_rd_valid_i;
  logic [PREG_W-1:0] rn_rd_idx_i;
  logic              rn_is_branch_i;
  logic [TAG_W-1:0]  alloc_tag_o;
  logic              cq_full_o;
  logic              wb_valid_i;
  logic [TAG_W-1:0]  wb_tag_i;
  logic              br_valid_i;
  logic              br_hit_i;
  logic              p_commit_valid_o;
  logic [PREG_W-1:0] p_commit_idx_o;
  logic              cq_empty_o;

  modport master (
    output rn_valid_i, rn_rd_valid_i, rn_rd_idx_i, rn_is_branch_i,
    output wb_valid_i, wb_tag_i, br_valid_i, br_hit_i,
    input  alloc_tag_o, cq_full_o, p_commit_valid_o, p_commit_idx_o, cq_empty_o
  );

  modport slave (
    input  rn_valid_i, rn_rd_valid_i, rn_rd_idx_i, rn_is_branch_i,
    input  wb_valid_i, wb_tag_i, br_valid_i, br_hit_i,
    output alloc_tag_o, cq_full_o, p_commit_valid_o, p_commit_idx_o, cq_empty_o
  );
endinterface

// File: rtl/commit_queue_ctrl.sv
// In-order commit sequencer: program-order queue with writeback tracking,
// in-order branch resolution, mispredict flush and one retirement per cycle.
module commit_queue_ctrl #(
  parameter int DEPTH  = 16,
  parameter int MAX_BR = 4,
  parameter int PREG_W = 6
) (
  input logic               clk,
  input logic               rst_ni,
  commit_queue_ctrl_if.slave cq
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = TAG_W + 1;
  localparam int BRC_W = $clog2(MAX_BR + 1);

  function automatic logic [DEPTH-1:0] onehot(input logic [TAG_W-1:0] tag);
    onehot      = '0;
    onehot[tag] = 1'b1;
  endfunction

  logic [TAG_W-1:0]  head_r, tail_r;
  logic [CNT_W-1:0]  count_r;
  logic [DEPTH-1:0]  valid_r, done_r, rd_valid_r, is_br_r, br_res_r;
  logic [PREG_W-1:0] rd_idx_r [DEPTH];
  logic [TAG_W-1:0]  br_fifo_r [MAX_BR];
  logic [BRC_W-1:0]  br_cnt_r;
  logic              p_commit_valid_r;
  logic [PREG_W-1:0] p_commit_idx_r;

  logic              full_s, resolve_s, flush_s, alloc_s, retire_s, br_push_s;
  logic [TAG_W-1:0]  br_tag_s, flush_off_s, flush_len_s;
  logic [CNT_W-1:0]  flush_cnt_s;
  logic [DEPTH-1:0]  wb_mask_s, res_mask_s, flush_mask_s, retire_mask_s, alloc_mask_s;
  logic [DEPTH-1:0]  done_eff_s, br_res_eff_s;
  logic [BRC_W-1:0]  br_pop_cnt_s;
  logic [TAG_W-1:0]  br_shift_s [MAX_BR];
  logic [TAG_W-1:0]  br_fifo_nxt_s [MAX_BR];

  assign full_s    = (count_r == CNT_W'(DEPTH)) || (br_cnt_r == BRC_W'(MAX_BR));
  assign resolve_s = cq.br_valid_i && (br_cnt_r != '0);
  assign br_tag_s  = br_fifo_r[0];
  assign flush_s   = resolve_s && !cq.br_hit_i;
  assign alloc_s   = cq.rn_valid_i && !full_s && !flush_s;
  assign br_push_s = alloc_s && cq.rn_is_branch_i;

  assign wb_mask_s    = (cq.wb_valid_i && valid_r[cq.wb_tag_i]) ? onehot(cq.wb_tag_i) : '0;
  assign res_mask_s   = resolve_s ? onehot(br_tag_s) : '0;
  assign alloc_mask_s = alloc_s ? onehot(tail_r) : '0;

  // Completion arriving this cycle lets the head retire at the same edge.
  assign done_eff_s   = done_r | wb_mask_s | res_mask_s;
  assign br_res_eff_s = br_res_r | res_mask_s;
  assign retire_s     = valid_r[head_r] && done_eff_s[head_r] &&
                        (!is_br_r[head_r] || br_res_eff_s[head_r]);
  assign retire_mask_s = retire_s ? onehot(head_r) : '0;

  assign flush_off_s = br_tag_s - head_r;
  assign flush_len_s = flush_off_s + TAG_W'(1);
  assign flush_cnt_s = (flush_len_s == '0) ? CNT_W'(DEPTH) : {1'b0, flush_len_s};

  // Entries whose age (offset from head) exceeds the mispredicted branch are wrong-path.
  always_comb begin
    flush_mask_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      flush_mask_s[i] = flush_s && (TAG_W'(TAG_W'(i) - head_r) > flush_off_s);
    end
  end

  assign br_pop_cnt_s = br_cnt_r - BRC_W'(resolve_s);

  // Branch-tag FIFO: pop shifts toward slot 0, push lands after the survivors.
  always_comb begin
    for (int i = 0; i < MAX_BR; i++) begin
      br_shift_s[i] = br_fifo_r[i];
    end
    for (int i = 0; i < MAX_BR - 1; i++) begin
      br_shift_s[i] = resolve_s ? br_fifo_r[i+1] : br_fifo_r[i];
    end
    for (int i = 0; i < MAX_BR; i++) begin
      br_fifo_nxt_s[i] = (br_push_s && (br_pop_cnt_s == BRC_W'(i))) ? tail_r : br_shift_s[i];
    end
  end

  // Queue state, branch FIFO and registered commit port.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      head_r           <= '0;
      tail_r           <= '0;
      count_r          <= '0;
      valid_r          <= '0;
      done_r           <= '0;
      rd_valid_r       <= '0;
      is_br_r          <= '0;
      br_res_r         <= '0;
      br_cnt_r         <= '0;
      p_commit_valid_r <= 1'b0;
      p_commit_idx_r   <= '0;
      for (int i = 0; i < DEPTH; i++) rd_idx_r[i] <= '0;
      for (int i = 0; i < MAX_BR; i++) br_fifo_r[i] <= '0;
    end else begin
      head_r     <= retire_s ? head_r + TAG_W'(1) : head_r;
      tail_r     <= flush_s ? br_tag_s + TAG_W'(1) : (alloc_s ? tail_r + TAG_W'(1) : tail_r);
      count_r    <= (flush_s ? flush_cnt_s : count_r + CNT_W'(alloc_s)) - CNT_W'(retire_s);
      valid_r    <= (valid_r & ~flush_mask_s & ~retire_mask_s) | alloc_mask_s;
      done_r     <= done_eff_s & ~flush_mask_s & ~retire_mask_s & ~alloc_mask_s;
      br_res_r   <= br_res_eff_s & ~flush_mask_s & ~retire_mask_s & ~alloc_mask_s;
      rd_valid_r <= (rd_valid_r & ~alloc_mask_s) | (alloc_mask_s & {DEPTH{cq.rn_rd_valid_i}});
      is_br_r    <= (is_br_r & ~alloc_mask_s) | (alloc_mask_s & {DEPTH{cq.rn_is_branch_i}});
      br_cnt_r   <= flush_s ? '0 : br_pop_cnt_s + BRC_W'(br_push_s);
      br_fifo_r  <= br_fifo_nxt_s;
      if (alloc_s) rd_idx_r[tail_r] <= cq.rn_rd_idx_i;
      p_commit_valid_r <= retire_s && rd_valid_r[head_r];
      if (retire_s && rd_valid_r[head_r]) p_commit_idx_r <= rd_idx_r[head_r];
    end
  end

  assign cq.alloc_tag_o      = tail_r;
  assign cq.cq_full_o        = full_s;
  assign cq.cq_empty_o       = (count_r == '0);
  assign cq.p_commit_valid_o = p_commit_valid_r;
  assign cq.p_commit_idx_o   = p_commit_idx_r;
endmodule

// File: tb/tb_commit_queue_ctrl.sv
// Scoreboard bench for commit_queue_ctrl: directed stimulus pushes expected
// commit indices; a negedge monitor pops and compares every commit pulse.
module tb_commit_queue_ctrl;
  localparam int DEPTH  = 16;
  localparam int MAX_BR = 4;
  localparam int PREG_W = 6;
  localparam int TAG_W  = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  commit_queue_ctrl_if #(.DEPTH(DEPTH), .PREG_W(PREG_W)) cq ();

  commit_queue_ctrl #(.DEPTH(DEPTH), .MAX_BR(MAX_BR), .PREG_W(PREG_W)) dut (
    .clk    (clk),
    .rst_ni (rst_ni),
    .cq     (cq)
  );

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int exp_v;

  // Monitor: every commit pulse must match the oldest expected index.
  always @(negedge clk) begin
    if (cq.p_commit_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL commit_unexpected: got idx %0d, required no commit", cq.p_commit_idx_o);
      end else begin
        exp_v = exp_q.pop_front();
        if (int'(cq.p_commit_idx_o) != exp_v) begin
          failures++;
          $display("FAIL commit_idx: got %0d, required %0d", cq.p_commit_idx_o, exp_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cq.rn_valid_i     = 1'b0;
    cq.rn_rd_valid_i  = 1'b0;
    cq.rn_rd_idx_i    = '0;
    cq.rn_is_branch_i = 1'b0;
    cq.wb_valid_i     = 1'b0;
    cq.wb_tag_i       = '0;
    cq.br_valid_i     = 1'b0;
    cq.br_hit_i       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic alloc(input logic rdv, input int rd, input logic br);
    check("alloc_while_full", int'(cq.cq_full_o), 0);
    cq.rn_valid_i     = 1'b1;
    cq.rn_rd_valid_i  = rdv;
    cq.rn_rd_idx_i    = PREG_W'(rd);
    cq.rn_is_branch_i = br;
    step();
    clear_inputs();
  endtask

  task automatic wb(input int tag);
    cq.wb_valid_i = 1'b1;
    cq.wb_tag_i   = TAG_W'(tag);
    step();
    clear_inputs();
  endtask

  task automatic resolve(input logic hit);
    cq.br_valid_i = 1'b1;
    cq.br_hit_i   = hit;
    step();
    clear_inputs();
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_ni = 1'b0;
    idle(2);
    rst_ni = 1'b1;
  endtask

  task automatic drained(input string name);
    idle(2);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    step();
    check("rst_full", int'(cq.cq_full_o), 0);
    check("rst_empty", int'(cq.cq_empty_o), 1);
    check("rst_alloc_tag", int'(cq.alloc_tag_o), 0);
    check("rst_commit_valid", int'(cq.p_commit_valid_o), 0);
    check("rst_commit_idx", int'(cq.p_commit_idx_o), 0);
    step();
    rst_ni = 1'b1;

    // Fill/drain
    for (int i = 0; i < 16; i++) begin
      check("fill_alloc_tag", int'(cq.alloc_tag_o), i);
      alloc(1'b1, 32 + i, 1'b0);
    end
    check("fill_full", int'(cq.cq_full_o), 1);
    check("fill_tag_wrap", int'(cq.alloc_tag_o), 0);
    check("fill_not_empty", int'(cq.cq_empty_o), 0);
    for (int t = 0; t < 16; t++) begin
      exp_q.push_back(32 + t);
      wb(t);
    end
    check("drain_empty", int'(cq.cq_empty_o), 1);
    check("drain_not_full", int'(cq.cq_full_o), 0);
    drained("drain_all_committed");

    // Out-of-order writeback
    alloc(1'b1, 40, 1'b0);
    alloc(1'b1, 41, 1'b0);
    alloc(1'b1, 42, 1'b0);
    wb(2);
    wb(1);
    idle(1);
    check("ooo_waiting", int'(cq.cq_empty_o), 0);
    exp_q.push_back(40);
    exp_q.push_back(41);
    exp_q.push_back(42);
    wb(0);
    idle(2);
    check("ooo_empty", int'(cq.cq_empty_o), 1);
    drained("ooo_committed");

    // Mispredict flush
    reset_dut();
    alloc(1'b1, 33, 1'b0);
    alloc(1'b0, 0, 1'b1);
    alloc(1'b1, 34, 1'b0);
    alloc(1'b1, 35, 1'b0);
    resolve(1'b0);
    check("flush_tail", int'(cq.alloc_tag_o), 2);
    check("flush_not_empty", int'(cq.cq_empty_o), 0);
    wb(2);
    idle(2);
    exp_q.push_back(33);
    wb(0);
    idle(2);
    check("flush_empty", int'(cq.cq_empty_o), 1);
    check("flush_tail_kept", int'(cq.alloc_tag_o), 2);
    alloc(1'b1, 36, 1'b0);
    idle(3);
    exp_q.push_back(36);
    wb(2);
    drained("flush_committed");
    resolve(1'b0);
    check("br_none_tail", int'(cq.alloc_tag_o), 3);
    check("br_none_empty", int'(cq.cq_empty_o), 1);

    // Branch cap
    for (int i = 0; i < 4; i++) alloc(1'b0, 0, 1'b1);
    check("brcap_full", int'(cq.cq_full_o), 1);
    check("brcap_tail", int'(cq.alloc_tag_o), 7);
    resolve(1'b1);
    check("brcap_release", int'(cq.cq_full_o), 0);
    for (int i = 0; i < 3; i++) resolve(1'b1);
    check("brcap_empty", int'(cq.cq_empty_o), 1);

    // Simultaneous retire, mispredict, allocate and flushed writeback
    reset_dut();
    alloc(1'b1, 50, 1'b0);
    alloc(1'b1, 51, 1'b0);
    alloc(1'b0, 0, 1'b1);
    alloc(1'b1, 53, 1'b0);
    wb(1);
    exp_q.push_back(50);
    exp_q.push_back(51);
    wb(0);
    cq.wb_valid_i     = 1'b1;
    cq.wb_tag_i       = TAG_W'(3);
    cq.br_valid_i     = 1'b1;
    cq.br_hit_i       = 1'b0;
    cq.rn_valid_i     = 1'b1;
    cq.rn_rd_valid_i  = 1'b1;
    cq.rn_rd_idx_i    = PREG_W'(60);
    step();
    clear_inputs();
    check("simul_tail", int'(cq.alloc_tag_o), 3);
    check("simul_not_empty", int'(cq.cq_empty_o), 0);
    idle(2);
    check("simul_empty", int'(cq.cq_empty_o), 1);
    alloc(1'b1, 54, 1'b0);
    idle(2);
    exp_q.push_back(54);
    wb(3);
    drained("simul_committed");

    // Wrap twice with a 3-cycle writeback lag
    reset_dut();
    for (int i = 0; i < 43; i++) begin
      if (i < 40) begin
        cq.rn_valid_i    = 1'b1;
        cq.rn_rd_valid_i = (i % 3 != 2);
        cq.rn_rd_idx_i   = PREG_W'(i + 8);
      end
      if (i >= 3) begin
        cq.wb_valid_i = 1'b1;
        cq.wb_tag_i   = TAG_W'((i - 3) % 16);
        if ((i - 3) % 3 != 2) exp_q.push_back((i - 3 + 8) % 64);
      end
      step();
      clear_inputs();
    end
    check("wrap_tail", int'(cq.alloc_tag_o), 8);
    check("wrap_empty", int'(cq.cq_empty_o), 1);
    drained("wrap_committed");

    // Reset asserted mid-stream
    alloc(1'b1, 1, 1'b0);
    alloc(1'b1, 2, 1'b0);
    alloc(1'b1, 3, 1'b0);
    wb(9);
    exp_q.push_back(1);
    exp_q.push_back(2);
    wb(8);
    check("pre_rst_commit_valid", int'(cq.p_commit_valid_o), 1);
    @(negedge clk);
    #1;
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_commit_valid", int'(cq.p_commit_valid_o), 0);
    check("midrst_commit_idx", int'(cq.p_commit_idx_o), 0);
    check("midrst_empty", int'(cq.cq_empty_o), 1);
    check("midrst_full", int'(cq.cq_full_o), 0);
    check("midrst_alloc_tag", int'(cq.alloc_tag_o), 0);
    idle(2);
    rst_ni = 1'b1;
    wb(10);
    wb(8);
    wb(9);
    idle(3);
    check("postrst_empty", int'(cq.cq_empty_o), 1);
    check("postrst_no_commits", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
